adc_frame_tx: RTL and testbench

Buffered UART framer for the sigma-delta ADC. Consumes the 12-bit filtered sample word and its one-cycle update strobe from the decimation filter stage. Stores samples in a small FIFO and transmits each one as two self-synchronising 8N1 bytes on a single pin, so an external logger can capture a continuous sample stream. It sits directly downstream of the filter/mux stage and drives one spare output pin.

---
 rtl/adc_frame_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_adc_frame_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_tx.sv
// adc_frame_tx: buffered UART framer for the sigma-delta ADC sample stream.
//
// Each 12-bit sample pushed with sample_valid is queued in a small circular
// FIFO and sent as two 8-bit UART bytes on tx:
//   byte0 = {1'b1, 1'b0, s[11:6]}   (bit 7 set marks the high byte)
//   byte1 = {2'b00, s[5:0]}
// Bytes are 8N1 by default. Defining ADC_FRAME_TX_PARITY_EN inserts an even
// parity bit between the data bits and the stop bit (8E1).
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   sample_in    12-bit filtered ADC word
//   sample_valid one-cycle push strobe
//   clr_ovf      clears the sticky overflow flag
//   tx           registered UART line, idles high
//   busy         serialiser is not idle
//   overflow     sticky, set when a push is dropped on a full FIFO
//   level        FIFO occupancy, excluding the sample being transmitted
module adc_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DEPTH_LOG2   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [11:0]           sample_in,
    input  logic                  sample_valid,
    input  logic                  clr_ovf,
    output logic                  tx,
    output logic                  busy,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned LVL_W   = DEPTH_LOG2 + 1;
    localparam int unsigned SAMPLE_W = 12;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef ADC_FRAME_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    // FIFO storage and pointers
    logic [SAMPLE_W-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      count_q,  count_d;

    // Serialiser state
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic                  byte_sel_q, byte_sel_d;
    logic [SAMPLE_W-1:0]   hold_q,  hold_d;
    logic                  tx_q,    tx_d;
    logic                  busy_q,  busy_d;
    logic                  ovf_q,   ovf_d;

    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  full;
    logic                  bit_end;
    logic [7:0]            cur_byte_d;

    // FIFO control: a push into a full FIFO is still accepted when the
    // serialiser pops in the same cycle.
    always_comb begin
        full     = (count_q == LVL_FULL);
        pop      = (state_q == IDLE) && (count_q != '0);
        push     = sample_valid && (!full || pop);
        drop     = sample_valid && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase

        // Setting overflow wins over clearing it in the same cycle.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Next-state and line-level logic for the byte serialiser
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        hold_d     = hold_q;
        bit_end    = (cnt_q == CNT_MAX);
        // Every state change happens on bit_end, so the wrap doubles as the
        // reload-on-entry of the bit timer.
        cnt_d      = bit_end ? '0 : cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pop) begin
                    hold_d     = mem_q[rd_ptr_q];
                    byte_sel_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef ADC_FRAME_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef ADC_FRAME_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (!byte_sel_q) begin
                        // Low byte follows the high byte with no idle gap.
                        byte_sel_d = 1'b1;
                        state_d    = START;
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cur_byte_d = byte_sel_d ? {2'b00, hold_d[5:0]} : {2'b10, hold_d[11:6]};

        // tx is computed from the next state so the register holds the
        // level of the bit that begins on this edge.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte_d[bit_idx_d];
`ifdef ADC_FRAME_TX_PARITY_EN
            PARITY:  tx_d = ^cur_byte_d;
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_sel_q <= 1'b0;
            hold_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_sel_q <= byte_sel_d;
            hold_q     <= hold_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign level    = count_q;

endmodule

// File: tb/tb_adc_frame_tx.sv
// Directed self-checking bench for adc_frame_tx (CLKS_PER_BIT=4, depth 4).
module tb_adc_frame_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned DL2 = 2;
`ifdef ADC_FRAME_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = 2 * NBITS * CPB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [11:0]    sample_in = '0;
    logic           sample_valid = 1'b0;
    logic           clr_ovf = 1'b0;
    logic           tx;
    logic           busy;
    logic           overflow;
    logic [DL2:0]   level;

    int total = 0;
    int bad   = 0;

    // Decoded bytes: {frame_ok, byte}
    logic [8:0] rx_q [$];

    adc_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH_LOG2   (DL2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clr_ovf      (clr_ovf),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .level        (level)
    );

    always #5 clk = ~clk;

    // Line receiver: samples mid-bit and queues each byte with a framing flag.
    initial begin : rx_mon
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
`ifdef ADC_FRAME_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                ok = ok && (tx === ^b);
`endif
                repeat (CPB) @(negedge clk);
                ok = ok && (tx === 1'b1);
                rx_q.push_back({ok, b});
                repeat (CPB - CPB / 2 - 1) @(negedge clk);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] enc(input logic [11:0] s, input bit hi);
        return hi ? {1'b1, 2'b10, s[11:6]} : {1'b1, 2'b00, s[5:0]};
    endfunction

    // Called on a negedge; the push is captured by the next rising edge.
    task automatic push(input logic [11:0] v);
        sample_valid = 1'b1;
        sample_in    = v;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input int budget);
        int b;
        b = budget;
        while (rx_q.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        chk("rx_count", rx_q.size(), n);
    endtask

    // Cycle-exact line check, starting on the first cycle of byte0's start bit.
    task automatic check_line(input logic [7:0] b0, input logic [7:0] b1);
        logic [10:0] bits;
        logic [7:0]  bv;
        for (int k = 0; k < 2; k++) begin
            bv = (k == 0) ? b0 : b1;
`ifdef ADC_FRAME_TX_PARITY_EN
            bits = {1'b1, ^bv, bv, 1'b0};
`else
            bits = {1'b0, 1'b1, bv, 1'b0};
`endif
            for (int j = 0; j < int'(NBITS); j++) begin
                for (int c = 0; c < int'(CPB); c++) begin
                    chk("line_bit", 32'(tx), 32'(bits[j]));
                    @(negedge clk);
                end
            end
        end
    endtask

    logic [11:0] sv [6];
    int          lvl_max;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single sample 0xA5C: byte0=0xA9, byte1=0x1C
        rx_q.delete();
        push(12'hA5C);
        chk("p1_level", 32'(level), 32'd1);
        chk("p1_tx", 32'(tx), 32'd1);
        chk("p1_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("p2_tx_fall", 32'(tx), 32'd0);
        chk("p2_busy", 32'(busy), 32'd1);
        chk("p2_level", 32'(level), 32'd0);
        check_line(8'hA9, 8'h1C);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_tx", 32'(tx), 32'd1);
        chk("rx_n1", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() >= 2) begin
            chk("rx_b0", 32'(rx_q[0]), 32'h1A9);
            chk("rx_b1", 32'(rx_q[1]), 32'h11C);
        end
        repeat (5) @(negedge clk);

        // Overflow: six back-to-back pushes
        rx_q.delete();
        sv[0] = 12'h0F1; sv[1] = 12'h7E2; sv[2] = 12'h813;
        sv[3] = 12'hFFF; sv[4] = 12'h000; sv[5] = 12'h555;
        sample_valid = 1'b1;
        sample_in = sv[0]; @(negedge clk); chk("ov_l1", 32'(level), 32'd1);
        sample_in = sv[1]; @(negedge clk); chk("ov_l2", 32'(level), 32'd1);
        sample_in = sv[2]; @(negedge clk); chk("ov_l3", 32'(level), 32'd2);
        sample_in = sv[3]; @(negedge clk); chk("ov_l4", 32'(level), 32'd3);
        sample_in = sv[4]; @(negedge clk); chk("ov_l5", 32'(level), 32'd4);
        chk("ov_not_yet", 32'(overflow), 32'd0);
        sample_in = sv[5]; @(negedge clk);
        sample_valid = 1'b0;
        chk("ov_l6", 32'(level), 32'd4);
        chk("ov_flag", 32'(overflow), 32'd1);
        wait_q(10, 5 * (FRAME + 1) + 60);
        for (int i = 0; i < 5; i++) begin
            if (rx_q.size() >= 2 * i + 2) begin
                chk("ov_hi", 32'(rx_q[2 * i]), 32'(enc(sv[i], 1'b1)));
                chk("ov_lo", 32'(rx_q[2 * i + 1]), 32'(enc(sv[i], 1'b0)));
            end
        end
        repeat (CPB * 2) @(negedge clk);
        chk("ov_idle_busy", 32'(busy), 32'd0);
        chk("ov_idle_level", 32'(level), 32'd0);
        chk("ov_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ov_clear", 32'(overflow), 32'd0);
        repeat (5) @(negedge clk);

        // Push into a full FIFO on the IDLE pop cycle
        rx_q.delete();
        sv[0] = 12'h321; sv[1] = 12'h654; sv[2] = 12'h987;
        sv[3] = 12'hCBA; sv[4] = 12'hFED; sv[5] = 12'h0A0;
        sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_in = sv[i];
            @(negedge clk);
        end
        sample_valid = 1'b0;
        chk("fp_full", 32'(level), 32'd4);
        repeat (FRAME - 3) @(negedge clk);
        chk("fp_idle_busy", 32'(busy), 32'd0);
        chk("fp_idle_level", 32'(level), 32'd4);
        push(sv[5]);
        chk("fp_level", 32'(level), 32'd4);
        chk("fp_ovf", 32'(overflow), 32'd0);
        chk("fp_busy", 32'(busy), 32'd1);
        wait_q(12, 6 * (FRAME + 1) + 60);
        for (int i = 0; i < 6; i++) begin
            if (rx_q.size() >= 2 * i + 2) begin
                chk("fp_hi", 32'(rx_q[2 * i]), 32'(enc(sv[i], 1'b1)));
                chk("fp_lo", 32'(rx_q[2 * i + 1]), 32'(enc(sv[i], 1'b0)));
            end
        end
        repeat (CPB * 3) @(negedge clk);

        // Reset during byte0 data bits, with samples still queued
        sample_valid = 1'b1;
        sample_in = 12'h111; @(negedge clk);
        sample_in = 12'h222; @(negedge clk);
        sample_in = 12'h333; @(negedge clk);
        sample_valid = 1'b0;
        repeat (CPB + 2) @(negedge clk);
        chk("mr_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_tx", 32'(tx), 32'd1);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_level", 32'(level), 32'd0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("mr_quiet_tx", 32'(tx), 32'd1);
        chk("mr_quiet_busy", 32'(busy), 32'd0);
        rx_q.delete();
        push(12'h123);
        wait_q(2, FRAME + 20);
        if (rx_q.size() >= 2) begin
            chk("mr_b0", 32'(rx_q[0]), 32'h184);
            chk("mr_b1", 32'(rx_q[1]), 32'h123);
        end
        repeat (CPB * 3) @(negedge clk);

        // Continuous stream, one sample every 100 cycles
        rx_q.delete();
        lvl_max = 0;
        for (int i = 0; i < 10; i++) begin
            push(12'((i * 12'h1A7) ^ 12'h5C3));
            for (int c = 0; c < 99; c++) begin
                if (int'(level) > lvl_max) lvl_max = int'(level);
                @(negedge clk);
            end
        end
        wait_q(20, FRAME + 20);
        chk("st_lvl_max", 32'(lvl_max <= 1), 32'd1);
        chk("st_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (rx_q.size() >= 2 * i + 2) begin
                chk("st_hi", 32'(rx_q[2 * i]), 32'(enc(12'((i * 12'h1A7) ^ 12'h5C3), 1'b1)));
                chk("st_lo", 32'(rx_q[2 * i + 1]), 32'(enc(12'((i * 12'h1A7) ^ 12'h5C3), 1'b0)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
